pipe_skid_reg: RTL

Parametrised, flushable pipeline register with a valid/ready handshake and a two-entry skid buffer. It is the next generation of the fixed inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) in the 5-stage core. Any stage can stall or be flushed without combinational ready paths crossing the boundary. The payload is an opaque packed vector: control fields plus data, concatenated by the instantiating stage.

---
 rtl/pipe_skid_reg.sv | 64 ++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: flushable valid/ready pipeline register with a two-entry skid buffer and stall counter
module pipe_skid_reg #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  output logic             up_ready_o,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  input  logic             dn_ready_i,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_e;
  state_e state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic up_fire, dn_fire;
  assign up_ready_o  = state_q != FULL;
  assign dn_valid_o  = state_q != EMPTY;
  assign dn_data_o   = dn_valid_o ? main_q : BUBBLE;
  assign occ_o       = state_q;
  assign stall_cnt_o = stall_q;
  assign up_fire     = up_valid_i & up_ready_o;
  assign dn_fire     = dn_valid_o & dn_ready_i;
  assign stall_d     = (dn_valid_o & ~dn_ready_i & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
  // next state and storage updates; flush overrides the handshake outcome
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: if (up_fire) begin state_d = BUSY; main_d = up_data_i; end
      BUSY: begin
        if (up_fire && dn_fire) main_d = up_data_i;
        else if (up_fire) begin state_d = FULL; skid_d = up_data_i; end
        else if (dn_fire) state_d = EMPTY;
      end
      FULL: if (dn_fire) begin state_d = BUSY; main_d = skid_q; end
      default: state_d = EMPTY;
    endcase
    if (flush_i) state_d = EMPTY;
  end
  // occupancy state and stall counter, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
    end
  end
  // payload storage needs no reset: it is only visible while an entry is valid
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end
endmodule
